serial_frame_receiver: RTL
==========================

// Module: serial_frame_receiver
// PURPOSE
//  Serial-to-parallel receiver that sits directly downstream of the 10-bit P->S shifter.
//  It takes that stage's serial output (MSB first) plus a per-bit enable and a start-of-frame
//  strobe, and rebuilds WIDTH-bit frames. Each completed frame is presented on a
//  valid/ready port to the consuming datapath.
//  Reception and output hand-off are double-buffered, so a new frame can shift in while
//  the previous one waits.
// PARAMETERS
//  WIDTH      10  frame length in bits; legal range 2..32
//  MSB_FIRST  1   1: first received bit lands in data[WIDTH-1]; 0: first bit lands in data[0]
// PORTS
//  Clock     in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-low
//  sIn       in   1      serial data bit, sampled only when bitEn=1
//  bitEn     in   1      a valid serial bit is present on sIn this cycle
//  start     in   1      qualifies sIn as bit 0 of a new frame; ignored when bitEn=0
//  data      out  WIDTH  assembled frame; stable while dValid=1
//  dValid    out  1      data holds an unconsumed frame
//  dReady    in   1      consumer accepts data when dValid&&dReady at a rising edge
//  busy      out  1      a frame is partially received (state SHIFT)
//  overrun   out  1      1-cycle pulse: a frame completed while the buffer was full; frame dropped
//  resync    out  1      1-cycle pulse: start arrived mid-frame; partial frame discarded
// BEHAVIOUR
//  Reset (rst=0 at an edge): state=IDLE, bit count=0, shift reg=0, data=0, dValid=0,
//   busy=0, overrun=0, resync=0. Reset overrides every other input.
//   A reset mid-frame discards the partial frame.
//  FSM, 2 states:
//   IDLE : on bitEn&&start, shift sIn in, count<=1, go to SHIFT.
//          bitEn without start is ignored: no shift, no flag.
//   SHIFT: on bitEn&&!start, shift sIn in and count++.
//          On bitEn&&start, pulse resync, restart with count<=1 and stay in SHIFT.
//          On bitEn when count==WIDTH-1, this is the last bit: complete the frame and go to IDLE.
//          bitEn=0 holds all state; there is no timeout.
//  Shift direction:
//   MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sIn}.
//   MSB_FIRST=0: sreg <= {sIn, sreg[WIDTH-1:1]}.
//  Completion at edge N: the frame is {sreg, last bit} in the shift order above.
//   - Buffer free, or dValid&&dReady at the same edge N: data <= frame, dValid <= 1.
//     Latency is 0 cycles after the last-bit edge: data is visible right after edge N.
//   - Buffer full and !dReady: old data is kept, the new frame is dropped, overrun=1 for one cycle.
//  Handshake: at an edge with dValid&&dReady and no completion, dValid <= 0 and data holds its value.
//   dValid never drops without a handshake. dReady while dValid=0 has no effect.
//  busy = (state==SHIFT). busy, overrun and resync are registered outputs.
//  Bit counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.
//  Frames may be back-to-back: the last bit of frame k, then start plus bit 0 of frame k+1
//   on the very next cycle, are both accepted.
// STRUCTURE
//  Shared package serial_pkg:
//   - typedef enum logic {S_IDLE, S_SHIFT} rx_state_t
//   - localparam FRAME_W_DEFAULT = 10, also used by the P->S shifter
//  Sub-module frame_out_buffer: WIDTH-bit holding register with valid/ready and overrun
//   generation.
//  The top level holds the FSM, the bit counter and the shift register.
// TESTING
//  1) Reset, then start with bits 1,0,0,0,0,1,0,1,0,0 on 10 consecutive bitEn cycles,
//     dReady=1 -> data=10'h214, dValid=1 right after the 10th edge, then 0 one edge later.
//  2) Same frame with bitEn low on alternate cycles -> identical data=10'h214 after 20 cycles;
//     busy=1 throughout reception.
//  3) dReady=0, send two frames 10'h214 then 10'h3FF -> data stays 10'h214, overrun pulses
//     once at the 2nd completion; raise dReady -> dValid falls.
//  4) Start after 4 bits of a frame, then 10 bits of 10'h155 -> resync pulses once;
//     data=10'h155.
//  5) rst=0 after 6 bits, release, send 10'h0AA -> no stray frame; data=10'h0AA.
//  6) MSB_FIRST=0, bits 0,0,1,0,1,0,0,0,0,1 -> data=10'h214. Back-to-back frames with a
//     1-cycle gap and dReady held 1 -> both delivered, no overrun.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame path.
// Used by the P->S shifter and the frame receiver.
package serial_pkg;

   typedef enum logic {S_IDLE, S_SHIFT} rx_state_t;

   localparam int FRAME_W_DEFAULT = 10;

endpackage

// File: rtl/frame_out_buffer.sv
// Output holding register for received frames.
// Presents one frame on valid/ready and flags frames dropped while full.
module frame_out_buffer
   import serial_pkg::*;
#(
   parameter int WIDTH = FRAME_W_DEFAULT
) (
   input  logic             Clock,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] frame,
   input  logic             dReady,
   output logic [WIDTH-1:0] data,
   output logic             dValid,
   output logic             overrun
);

   logic             room;
   logic [WIDTH-1:0] data_n;
   logic             valid_n;
   logic             ovr_n;

   assign room = !dValid || dReady;

   // Accept a completed frame when free or draining; else drop it and flag.
   always_comb begin
      data_n  = data;
      valid_n = dValid;
      ovr_n   = 1'b0;
      if (load) begin
         if (room) begin
            data_n  = frame;
            valid_n = 1'b1;
         end else begin
            ovr_n = 1'b1;
         end
      end else if (dValid && dReady) begin
         valid_n = 1'b0;
      end
   end

   // Holding register with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!rst) begin
         data    <= '0;
         dValid  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         data    <= data_n;
         dValid  <= valid_n;
         overrun <= ovr_n;
      end
   end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel frame receiver behind the P->S shifter.
// FSM, bit counter and shift register; frames hand off to frame_out_buffer.
module serial_frame_receiver
   import serial_pkg::*;
#(
   parameter int WIDTH     = FRAME_W_DEFAULT,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             Clock,
   input  logic             rst,
   input  logic             sIn,
   input  logic             bitEn,
   input  logic             start,
   output logic [WIDTH-1:0] data,
   output logic             dValid,
   input  logic             dReady,
   output logic             busy,
   output logic             overrun,
   output logic             resync
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   rx_state_t        state;
   rx_state_t        state_n;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_n;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_n;
   logic [WIDTH-1:0] shifted;
   logic             complete;
   logic             resync_n;

   // Incoming bit appended in the configured bit order.
   always_comb begin
      if (MSB_FIRST) begin
         shifted = {sreg[WIDTH-2:0], sIn};
      end else begin
         shifted = {sIn, sreg[WIDTH-1:1]};
      end
   end

   // Next-state logic: start always begins a frame, last bit completes it.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sreg_n   = sreg;
      complete = 1'b0;
      resync_n = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bitEn && start) begin
               sreg_n  = shifted;
               cnt_n   = CW'(1);
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bitEn && start) begin
               sreg_n   = shifted;
               cnt_n    = CW'(1);
               resync_n = 1'b1;
            end else if (bitEn && cnt == LAST) begin
               sreg_n   = shifted;
               cnt_n    = '0;
               complete = 1'b1;
               state_n  = S_IDLE;
            end else if (bitEn) begin
               sreg_n = shifted;
               cnt_n  = cnt + CW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State, counter, shift register and registered status flags.
   always_ff @(posedge Clock) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         sreg   <= '0;
         busy   <= 1'b0;
         resync <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         sreg   <= sreg_n;
         busy   <= (state_n == S_SHIFT);
         resync <= resync_n;
      end
   end

   frame_out_buffer #(
      .WIDTH (WIDTH)
   ) u_buf (
      .Clock   (Clock),
      .rst     (rst),
      .load    (complete),
      .frame   (shifted),
      .dReady  (dReady),
      .data    (data),
      .dValid  (dValid),
      .overrun (overrun)
   );

endmodule
